// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 fetch sequencer.
// PC mux selects, fetch FSM states and pending-redirect kinds.
package msrv32_pkg;

   localparam logic [1:0] PC_SRC_BOOT = 2'b00;
   localparam logic [1:0] PC_SRC_EPC  = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP = 2'b10;
   localparam logic [1:0] PC_SRC_NEXT = 2'b11;

   typedef enum logic [1:0] {
      FS_BOOT     = 2'b00,
      FS_RUN      = 2'b01,
      FS_REDIRECT = 2'b10
   } fetch_state_t;

   typedef enum logic [1:0] {
      PEND_NONE = 2'b00,
      PEND_TRAP = 2'b01,
      PEND_EPC  = 2'b10
   } pend_t;

   typedef struct packed {
      logic [1:0] pc_src;
      logic       pc_write_en;
      logic       flush;
      logic       i_req;
   } fetch_ctl_t;

   function automatic logic [1:0] pend_src(pend_t p);
      return (p == PEND_EPC) ? PC_SRC_EPC : PC_SRC_TRAP;
   endfunction

endpackage

// File: rtl/msrv32_fetch_wait_timer.sv
// Saturating AHB wait-state counter with a single timeout pulse.
// The pulse fires on the wait cycle that brings the count to the limit.
module msrv32_fetch_wait_timer
   import msrv32_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 7
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic req_in,
   input  logic ready_in,
   output logic timeout_out
);

   localparam logic [CNT_WIDTH-1:0] LIMIT =
      CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] LAST =
      CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic ENABLE = (TIMEOUT_CYCLES != 0);

   logic [CNT_WIDTH-1:0] wait_cnt;
   logic                 wait_inc;
   logic                 at_limit;

   assign wait_inc = req_in & ~ready_in;
   assign at_limit = (wait_cnt == LIMIT);

   always_ff @(posedge clk_in) begin
      if (rst_in || ready_in) begin
         wait_cnt <= '0;
      end else if (wait_inc && !at_limit) begin
         wait_cnt <= wait_cnt + CNT_WIDTH'(1);
      end
   end

   // Saturation keeps the count off LAST until a clear, so no repeat.
   assign timeout_out = ENABLE & wait_inc &
                        (wait_cnt == LAST);

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// Fetch sequencer: PC source select, PC write enable and fetch handshake.
// Redirects are registered, so pc_src never follows trap/mret combinationally.
module msrv32_fetch_ctrl
   import msrv32_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 7
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       ahb_ready_in,
   input  logic       trap_taken_in,
   input  logic       mret_in,
   input  logic       branch_taken_in,
   input  logic       misaligned_instr_in,
   output logic [1:0] pc_src_out,
   output logic       pc_write_en_out,
   output logic       flush_out,
   output logic       i_req_out,
   output logic       stall_out,
   output logic       instr_misaligned_out,
   output logic       fetch_timeout_out
);

   fetch_state_t state_q;
   fetch_state_t state_d;
   pend_t        pend_q;
   pend_t        pend_d;
   fetch_ctl_t   ctl;
   logic         rst_q;
   logic         mis_q;
   logic         mis_d;
   logic         bad_target;

   assign bad_target = branch_taken_in &
                       misaligned_instr_in;

   // rst_q stretches reset outputs into the cycle after the reset edge.
   always_ff @(posedge clk_in) begin
      rst_q <= rst_in;
      if (rst_in) begin
         state_q <= FS_BOOT;
         pend_q  <= PEND_NONE;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      mis_d   = 1'b0;
      ctl     = '{pc_src:      PC_SRC_BOOT,
                  pc_write_en: 1'b0,
                  flush:       1'b1,
                  i_req:       1'b0};
      if (!rst_q) begin
         unique case (state_q)
            FS_BOOT: begin
               ctl.pc_src      = PC_SRC_BOOT;
               ctl.i_req       = 1'b1;
               ctl.flush       = 1'b1;
               ctl.pc_write_en = ahb_ready_in;
               if (ahb_ready_in) begin
                  state_d = FS_RUN;
               end
            end
            FS_RUN: begin
               ctl.pc_src      = PC_SRC_NEXT;
               ctl.i_req       = 1'b1;
               ctl.flush       = 1'b0;
               ctl.pc_write_en = ahb_ready_in &
                                 ~bad_target;
               mis_d           = ahb_ready_in &
                                 bad_target;
               priority case (1'b1)
                  trap_taken_in: begin
                     pend_d  = PEND_TRAP;
                     state_d = FS_REDIRECT;
                  end
                  mret_in: begin
                     pend_d  = PEND_EPC;
                     state_d = FS_REDIRECT;
                  end
                  default: ;
               endcase
            end
            FS_REDIRECT: begin
               ctl.pc_src      = pend_src(pend_q);
               ctl.i_req       = 1'b1;
               ctl.flush       = 1'b1;
               ctl.pc_write_en = ahb_ready_in;
               // A trap overrides EPC and chains onto an accepted redirect.
               priority case (1'b1)
                  trap_taken_in: begin
                     pend_d = PEND_TRAP;
                  end
                  ahb_ready_in: begin
                     pend_d  = PEND_NONE;
                     state_d = FS_RUN;
                  end
                  default: ;
               endcase
            end
            default: begin
               state_d = FS_BOOT;
               pend_d  = PEND_NONE;
            end
         endcase
      end
   end

   assign pc_src_out           = ctl.pc_src;
   assign pc_write_en_out      = ctl.pc_write_en;
   assign flush_out            = ctl.flush;
   assign i_req_out            = ctl.i_req;
   assign stall_out            = ctl.i_req &
                                 ~ahb_ready_in;
   assign instr_misaligned_out = mis_q;

   msrv32_fetch_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_wait_timer (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .req_in      (ctl.i_req),
      .ready_in    (ahb_ready_in),
      .timeout_out (fetch_timeout_out)
   );

endmodule

// File: doc/msrv32_fetch_ctrl.md
Name: msrv32_fetch_ctrl

Overview:
- Sequencer for the PC-selection datapath and the instruction-fetch bus handshake.
- Each cycle it decides which PC source (boot, EPC, trap vector, next PC) is applied, and whether the PC register may update.
- Holds redirect events across AHB wait states, suppresses PC writes to misaligned branch targets, and flags stalled fetches with a timeout.
- Sits between the machine-control/CSR unit, the branch unit, and the PC mux/PC register.

Parameters:
- TIMEOUT_CYCLES, 64: consecutive wait-state cycles before fetch_timeout_out pulses; 0 disables the timeout.
- CNT_WIDTH, 7: wait counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  synchronous active-high reset
- ahb_ready_in  input  1  instruction bus ready; a fetch address is accepted only when high
- trap_taken_in  input  1  trap entry request from machine control
- mret_in  input  1  return-from-trap request
- branch_taken_in  input  1  next PC is a branch/jump target
- misaligned_instr_in  input  1  selected next-PC target is not 4-byte aligned
- pc_src_out  output  2  00 boot, 01 EPC, 10 trap vector, 11 next PC
- pc_write_en_out  output  1  PC register load enable
- flush_out  output  1  kill the instruction currently in fetch/decode
- i_req_out  output  1  instruction fetch request
- stall_out  output  1  pipeline hold, high while i_req_out=1 and ahb_ready_in=0
- instr_misaligned_out  output  1  one-cycle pulse to the trap unit
- fetch_timeout_out  output  1  one-cycle pulse on wait-state timeout

Behaviour:
- State register: BOOT, RUN, REDIRECT.
- Pending register: NONE, TRAP, EPC.
- Wait counter: wait_cnt.
- All inputs are sampled at the rising edge. A redirect requested in cycle N drives its pc_src_out from cycle N+1. There is no combinational path from trap_taken_in or mret_in to pc_src_out.
- Reset (rst_in=1 at an edge), effective at any time including mid-redirect:
  - state=BOOT, pending=NONE, wait_cnt=0.
  - Outputs during reset: pc_src_out=00, pc_write_en_out=0, flush_out=1, i_req_out=0, stall_out=0, instr_misaligned_out=0, fetch_timeout_out=0.
- BOOT (first cycle after reset deasserts):
  - pc_src_out=00, i_req_out=1, flush_out=1, pc_write_en_out=ahb_ready_in.
  - Go to RUN when ahb_ready_in=1; otherwise stay.
  - trap_taken_in and mret_in are ignored in BOOT.
- RUN:
  - pc_src_out=11, i_req_out=1, flush_out=0.
  - pc_write_en_out = ahb_ready_in & ~(branch_taken_in & misaligned_instr_in).
  - Priority: trap_taken_in > mret_in.
    - trap_taken_in=1: pending=TRAP, go to REDIRECT.
    - else mret_in=1: pending=EPC, go to REDIRECT.
  - Misaligned target: if branch_taken_in & misaligned_instr_in & ahb_ready_in, then instr_misaligned_out=1 next cycle (registered single pulse) and the PC is not written. The trap unit then answers with trap_taken_in.
- REDIRECT:
  - pc_src_out=10 if pending=TRAP, 01 if pending=EPC.
  - flush_out=1, i_req_out=1, pc_write_en_out=ahb_ready_in.
  - When ahb_ready_in=1: go to RUN, pending=NONE.
  - trap_taken_in while pending=EPC and not yet accepted: pending becomes TRAP, stay.
  - mret_in while pending=TRAP: ignored.
  - trap_taken_in in the acceptance cycle: pending=TRAP, stay in REDIRECT for one more redirect.
- stall_out = i_req_out & ~ahb_ready_in, in every state.
- Wait counter:
  - Increments each cycle with i_req_out=1 & ahb_ready_in=0; saturates at TIMEOUT_CYCLES.
  - Clears to 0 on any ahb_ready_in=1 cycle or on reset.
  - fetch_timeout_out pulses exactly once, in the cycle wait_cnt transitions to TIMEOUT_CYCLES.
  - No repeat pulse until the counter has been cleared.
- All outputs are glitch-free functions of registered state plus ahb_ready_in, branch_taken_in and misaligned_instr_in.

Decomposition:
- Shared package msrv32_pkg:
  - PC_SRC_BOOT=2'b00, PC_SRC_EPC=2'b01, PC_SRC_TRAP=2'b10, PC_SRC_NEXT=2'b11.
  - fetch state encoding and pending encoding.
- One natural sub-module: msrv32_fetch_wait_timer (saturating wait counter plus single-pulse timeout).

Test Plan:
- Reset release with ahb_ready_in=1 → cycle 1: pc_src_out=00, pc_write_en_out=1, flush_out=1; cycle 2: pc_src_out=11, flush_out=0.
- In RUN, pulse trap_taken_in and mret_in in the same cycle with ahb_ready_in=0 for 3 cycles → pc_src_out=10 held 3 cycles, stall_out=1; on ready: pc_write_en_out=1, then pc_src_out=11.
- mret_in, then trap_taken_in one cycle later while ahb_ready_in=0 → pc_src_out goes 01 then 10; only the trap vector is written.
- branch_taken_in=1, misaligned_instr_in=1, ahb_ready_in=1 in RUN → pc_write_en_out=0 that cycle; instr_misaligned_out=1 for exactly one cycle next.
- TIMEOUT_CYCLES=4, ahb_ready_in=0 for 10 cycles → fetch_timeout_out pulses once, in the 4th wait cycle; after ready and a further 4 waits, it pulses again.
- rst_in asserted mid-REDIRECT (pending=TRAP) → next cycle pc_src_out=00, i_req_out=0, pending cleared; after release the boot sequence repeats.
